// File: rtl/bola_fisica_pkg.sv
// Shared definitions for the breakout ball engine: states, screen defaults,
// direction encoding and coordinate widths.
package bola_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  localparam int CW = 10;  // coordinate width on ports
  localparam int IW = 12;  // signed width used for next-position math

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    MOVENDO = 2'd1,
    FIM     = 2'd2
  } estado_t;

  function automatic logic signed [IW-1:0] ext(input logic [CW-1:0] v);
    return $signed({{(IW-CW){1'b0}}, v});
  endfunction

endpackage

// File: rtl/bola_fisica_if.sv
// Game-side bundle of the ball engine: paddle/brick/control inputs and
// the position, lives and status outputs.
interface bola_fisica_if;
  import bola_pkg::*;

  logic          pausa;
  logic          reiniciar;
  logic          lancar;
  logic [CW-1:0] raquete_x;
  logic [CW-1:0] raquete_y;
  logic [CW-1:0] raquete_larg;
  logic          colisao_bloco;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic [CW-1:0] raio;
  logic [2:0]    vidas;
  logic          perdeu;
  logic          fim_jogo;

  modport master (
    output pausa, reiniciar, lancar, raquete_x, raquete_y, raquete_larg, colisao_bloco,
    input  x, y, raio, vidas, perdeu, fim_jogo
  );

  modport slave (
    input  pausa, reiniciar, lancar, raquete_x, raquete_y, raquete_larg, colisao_bloco,
    output x, y, raio, vidas, perdeu, fim_jogo
  );

endinterface

// File: rtl/bola_fisica_divisor_tick.sv
// Free-running 0..DIV-1 counter producing a one-cycle movement enable.
// Shared by the ball, paddle and brick engines.
module divisor_tick #(
  parameter int DIV = 50000
) (
  input  logic CLOCK_50,
  input  logic reset,
  output logic tick
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [TW-1:0] r_cnt;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_cnt == TW'(DIV - 1)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign tick = (r_cnt == TW'(DIV - 1));

endmodule

// File: rtl/bola_fisica.sv
// Ball engine: moves the ball, bounces it off walls, ceiling, paddle and
// bricks, detects floor loss and keeps the life count.
//
// state   | meaning
// ESPERA  | ball parked on the paddle, waiting for lancar
// MOVENDO | ball in flight, one step per tick
// FIM     | no lives left, ball frozen until reiniciar
module bola_fisica
  import bola_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int RAIO     = 5,
  parameter int DIV      = 50000,
  parameter int VIDAS    = 3,
  parameter int VEL_MAX  = 4,
  parameter int ACELERA  = 8
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  bola_fisica_if.slave bus
);

  localparam logic [1:0] S_ESPERA  = ESPERA;
  localparam logic [1:0] S_MOVENDO = MOVENDO;
  localparam logic [1:0] S_FIM     = FIM;
  localparam int         HW        = $clog2(ACELERA + 1);

  localparam logic signed [IW-1:0] K_ZERO = '0;
  localparam logic signed [IW-1:0] K_RAIO = IW'(RAIO);
  localparam logic signed [IW-1:0] K_XMAX = IW'(SCREEN_W - 1);
  localparam logic signed [IW-1:0] K_YMAX = IW'(SCREEN_H - 1);

  logic          w_tick;
  logic [1:0]    r_estado;
  logic [CW-1:0] r_x, r_y;
  logic [3:0]    r_vel;
  logic          r_dx, r_dy;
  logic          r_perdeu;
  logic          r_bloco_pend;
  logic [2:0]    r_vidas;
  logic [HW-1:0] r_hits;

  logic signed [IW-1:0] w_x, w_y, w_vel, w_nx, w_ny, w_rx, w_ry, w_rl;
  logic [CW-1:0]        w_x_prox, w_y_prox, w_x_esp, w_y_esp;
  logic                 w_dx_prox, w_dy_prox, w_hit, w_chao, w_bloco;
  logic [2:0]           w_vidas_dec;

  divisor_tick #(.DIV(DIV)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .tick     (w_tick)
  );

  always_comb begin
    w_x   = ext(r_x);
    w_y   = ext(r_y);
    w_rx  = ext(bus.raquete_x);
    w_ry  = ext(bus.raquete_y);
    w_rl  = ext(bus.raquete_larg);
    w_vel = $signed({{(IW-4){1'b0}}, r_vel});
    w_nx  = (r_dx == DIR_POS) ? w_x + w_vel : w_x - w_vel;
    w_ny  = (r_dy == DIR_POS) ? w_y + w_vel : w_y - w_vel;

    w_bloco = r_bloco_pend | bus.colisao_bloco;
    w_hit   = (r_dy == DIR_POS) && (w_y + K_RAIO < w_ry) && (w_ry <= w_ny + K_RAIO) &&
              (w_rx <= w_nx) && (w_nx <= w_rx + w_rl);
    w_chao  = !w_hit && (w_ny + K_RAIO >= K_YMAX);

    w_x_prox  = w_nx[CW-1:0];
    w_dx_prox = r_dx;
    if (w_nx - K_RAIO <= K_ZERO) begin
      w_x_prox  = CW'(RAIO);
      w_dx_prox = DIR_POS;
    end else if (w_nx + K_RAIO >= K_XMAX) begin
      w_x_prox  = CW'(SCREEN_W - 1 - RAIO);
      w_dx_prox = DIR_NEG;
    end

    // paddle overrides both ceiling and brick on the vertical axis
    w_y_prox  = w_ny[CW-1:0];
    w_dy_prox = r_dy;
    if (w_hit) begin
      w_y_prox  = bus.raquete_y - CW'(RAIO + 1);
      w_dy_prox = DIR_NEG;
    end else begin
      if (w_ny - K_RAIO <= K_ZERO) begin
        w_y_prox  = CW'(RAIO);
        w_dy_prox = DIR_POS;
      end
      if (w_bloco) begin
        w_dy_prox = ~w_dy_prox;
      end
    end

    w_x_esp     = bus.raquete_x + (bus.raquete_larg >> 1);
    w_y_esp     = bus.raquete_y - CW'(RAIO + 1);
    w_vidas_dec = r_vidas - 3'd1;
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_estado     <= S_ESPERA;
      r_vidas      <= 3'(VIDAS);
      r_vel        <= 4'd1;
      r_dx         <= DIR_POS;
      r_dy         <= DIR_NEG;
      r_x          <= CW'(SCREEN_W / 2);
      r_y          <= CW'(SCREEN_H - 40);
      r_perdeu     <= 1'b0;
      r_bloco_pend <= 1'b0;
      r_hits       <= '0;
    end else begin
      r_perdeu <= 1'b0;
      if (bus.colisao_bloco) begin
        r_bloco_pend <= 1'b1;
      end
      if (bus.reiniciar) begin
        r_estado     <= S_ESPERA;
        r_vidas      <= 3'(VIDAS);
        r_vel        <= 4'd1;
        r_dx         <= DIR_POS;
        r_dy         <= DIR_NEG;
        r_hits       <= '0;
        r_bloco_pend <= 1'b0;
      end else begin
        case (r_estado)
          S_ESPERA: begin
            r_x <= w_x_esp;
            r_y <= w_y_esp;
            if (bus.lancar && !bus.pausa) begin
              r_estado <= S_MOVENDO;
              r_dx     <= DIR_POS;
              r_dy     <= DIR_NEG;
            end
          end
          S_MOVENDO: begin
            if (w_tick && !bus.pausa) begin
              r_bloco_pend <= 1'b0;
              r_x          <= w_x_prox;
              r_y          <= w_y_prox;
              r_dx         <= w_dx_prox;
              r_dy         <= w_dy_prox;
              if (w_hit) begin
                if (r_hits == HW'(ACELERA - 1)) begin
                  r_hits <= '0;
                  r_vel  <= (r_vel < 4'(VEL_MAX)) ? r_vel + 4'd1 : r_vel;
                end else begin
                  r_hits <= r_hits + HW'(1);
                end
              end
              if (w_chao) begin
                r_perdeu <= 1'b1;
                r_vidas  <= w_vidas_dec;
                r_estado <= (w_vidas_dec != 3'd0) ? S_ESPERA : S_FIM;
              end
            end
          end
          S_FIM: ;
          default: r_estado <= S_ESPERA;
        endcase
      end
    end
  end

  assign bus.x        = r_x;
  assign bus.y        = r_y;
  assign bus.raio     = CW'(RAIO);
  assign bus.vidas    = r_vidas;
  assign bus.perdeu   = r_perdeu;
  assign bus.fim_jogo = (r_estado == S_FIM);

endmodule

// File: tb/tb_bola_fisica.sv
// Directed bench for bola_fisica with DIV=4: paddle tracking table plus
// hand-computed sequences for walls, ceiling, paddle speed-up, loss and reset.
module tb_bola_fisica;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_ok;
  int   tb_cnt;

  bola_fisica_if bus();

  bola_fisica #(.DIV(4)) dut (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // tick phase expected from a 0..3 counter released together with the DUT
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= 0;
    else        tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;
  end

  typedef struct {
    logic [9:0] rx;
    logic [9:0] ry;
    logic [9:0] rl;
    logic       pausa;
    logic [9:0] ex;
    logic [9:0] ey;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_ok++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic set_pad(input int px, input int py, input int pl);
    bus.raquete_x    = 10'(px);
    bus.raquete_y    = 10'(py);
    bus.raquete_larg = 10'(pl);
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0:       bus.lancar        = 1'b1;
      1:       bus.reiniciar     = 1'b1;
      default: bus.colisao_bloco = 1'b1;
    endcase
    @(negedge clk);
    bus.lancar        = 1'b0;
    bus.reiniciar     = 1'b0;
    bus.colisao_bloco = 1'b0;
  endtask

  // returns 1 ns after the next clock edge that carries a tick
  task automatic next_tick();
    int n;
    n = 0;
    while (tb_cnt != 3 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) begin
      n_chk++;
      $display("FAIL tick_wait: got no tick in %0d cycles, expected one within 4", n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic launch_from(input int px, input int py, input int pl,
                             input int ax, input int ay, input int al);
    set_pad(px, py, pl);
    pulse(1);
    @(posedge clk);
    #1;
    pulse(0);
    set_pad(ax, ay, al);
  endtask

  task automatic lose_life(input int exp_vidas);
    int  k;
    bit  seen;
    set_pad(480, 450, 40);
    @(posedge clk);
    #1;
    pulse(2);
    pulse(0);
    set_pad(0, 450, 40);
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 40) begin
      next_tick();
      k++;
      if (bus.perdeu) seen = 1'b1;
    end
    chk("perdeu_tick", seen ? k : -1, 32);
    @(posedge clk);
    #1;
    chk("perdeu_one_cycle", int'(bus.perdeu), 0);
    chk("vidas_after_loss", int'(bus.vidas), exp_vidas);
    if (exp_vidas > 0) begin
      chk("espera_track_x", int'(bus.x), 20);
      chk("espera_track_y", int'(bus.y), 444);
      chk("fim_low", int'(bus.fim_jogo), 0);
    end else begin
      chk("fim_high", int'(bus.fim_jogo), 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_ok  = 0;
    rst_n = 1'b0;
    bus.pausa = 1'b0;
    bus.reiniciar = 1'b0;
    bus.lancar = 1'b0;
    bus.colisao_bloco = 1'b0;
    set_pad(0, 0, 0);

    vecs[0] = '{10'd300, 10'd450, 10'd40, 1'b0, 10'd320, 10'd444};
    vecs[1] = '{10'd0,   10'd100, 10'd10, 1'b0, 10'd5,   10'd94};
    vecs[2] = '{10'd616, 10'd106, 10'd40, 1'b0, 10'd636, 10'd100};
    vecs[3] = '{10'd100, 10'd300, 10'd41, 1'b0, 10'd120, 10'd294};
    vecs[4] = '{10'd600, 10'd20,  10'd80, 1'b1, 10'd640, 10'd14};

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", int'(bus.x), 320);
    chk("rst_y", int'(bus.y), 440);
    chk("rst_vidas", int'(bus.vidas), 3);
    chk("rst_perdeu", int'(bus.perdeu), 0);
    chk("rst_fim", int'(bus.fim_jogo), 0);
    chk("raio", int'(bus.raio), 5);
    @(negedge clk);
    rst_n = 1'b1;

    // paddle tracking in ESPERA, including under pausa
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_pad(vecs[i].rx, vecs[i].ry, vecs[i].rl);
      bus.pausa = vecs[i].pausa;
      @(posedge clk);
      #1;
      chk($sformatf("track_x[%0d]", i), int'(bus.x), int'(vecs[i].ex));
      chk($sformatf("track_y[%0d]", i), int'(bus.y), int'(vecs[i].ey));
    end
    bus.pausa = 1'b0;

    // launch, step, pause freeze, resume
    launch_from(300, 450, 40, 300, 450, 40);
    next_tick();
    chk("launch_x", int'(bus.x), 321);
    chk("launch_y", int'(bus.y), 443);
    bus.pausa = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("pausa_x", int'(bus.x), 321);
    chk("pausa_y", int'(bus.y), 443);
    bus.pausa = 1'b0;
    next_tick();
    chk("resume_x", int'(bus.x), 322);
    chk("resume_y", int'(bus.y), 442);

    // right wall
    launch_from(616, 106, 40, 0, 450, 40);
    next_tick();
    chk("rwall_x", int'(bus.x), 634);
    chk("rwall_y", int'(bus.y), 99);
    next_tick();
    chk("rwall_dx_x", int'(bus.x), 633);
    chk("rwall_dx_y", int'(bus.y), 98);

    // ceiling
    launch_from(300, 12, 40, 0, 450, 40);
    next_tick();
    chk("ceil_y", int'(bus.y), 5);
    chk("ceil_x", int'(bus.x), 321);
    next_tick();
    chk("ceil_dy_y", int'(bus.y), 6);

    // corner: both axes flip on the same tick
    launch_from(614, 12, 40, 0, 450, 40);
    next_tick();
    chk("corner_x", int'(bus.x), 634);
    chk("corner_y", int'(bus.y), 5);
    next_tick();
    chk("corner_dx_x", int'(bus.x), 633);
    chk("corner_dy_y", int'(bus.y), 6);

    // eight paddle hits raise the speed to 2 (hits at ticks 19,38,...,152)
    launch_from(0, 20, 639, 0, 20, 639);
    for (int i = 0; i < 133; i++) next_tick();
    chk("hit7_y", int'(bus.y), 14);
    next_tick();
    chk("vel1_x", int'(bus.x), 453);
    chk("vel1_y", int'(bus.y), 13);
    for (int i = 0; i < 18; i++) next_tick();
    chk("hit8_y", int'(bus.y), 14);
    next_tick();
    chk("vel2_x", int'(bus.x), 473);
    chk("vel2_y", int'(bus.y), 12);

    // paddle beats a pending brick; brick alone inverts dy (speed back to 1)
    launch_from(0, 20, 639, 0, 20, 639);
    for (int i = 0; i < 18; i++) next_tick();
    chk("pre_hit_y", int'(bus.y), 14);
    pulse(2);
    next_tick();
    chk("hit_bloco_y", int'(bus.y), 14);
    next_tick();
    chk("hit_bloco_dy_y", int'(bus.y), 13);
    pulse(2);
    next_tick();
    chk("bloco_y", int'(bus.y), 12);
    next_tick();
    chk("bloco_dy_y", int'(bus.y), 13);

    // three floor losses end the game
    set_pad(300, 450, 40);
    pulse(1);
    @(posedge clk);
    #1;
    lose_life(2);
    lose_life(1);
    lose_life(0);
    pulse(0);
    repeat (3) next_tick();
    chk("fim_lancar_fim", int'(bus.fim_jogo), 1);
    chk("fim_lancar_vidas", int'(bus.vidas), 0);
    chk("fim_frozen_x", int'(bus.x), 532);
    chk("fim_no_perdeu", int'(bus.perdeu), 0);

    // reiniciar from FIM
    set_pad(300, 450, 40);
    pulse(1);
    @(posedge clk);
    #1;
    chk("rein_vidas", int'(bus.vidas), 3);
    chk("rein_fim", int'(bus.fim_jogo), 0);
    chk("rein_x", int'(bus.x), 320);
    chk("rein_y", int'(bus.y), 444);
    pulse(0);
    set_pad(0, 450, 40);
    next_tick();
    chk("rein_vel_x", int'(bus.x), 321);
    next_tick();
    chk("rein_vel_y", int'(bus.y), 442);

    // asynchronous reset in flight
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_x", int'(bus.x), 320);
    chk("arst_y", int'(bus.y), 440);
    chk("arst_vidas", int'(bus.vidas), 3);
    chk("arst_perdeu", int'(bus.perdeu), 0);
    chk("arst_fim", int'(bus.fim_jogo), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_track_x", int'(bus.x), 20);
    chk("arst_track_y", int'(bus.y), 444);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule

// File: doc/bola_fisica.md
Name: bola_fisica

Overview:
- Parametrised ball engine for the VGA breakout game.
- Moves the ball in 2D at a programmable step rate.
- Bounces it off the side walls, the ceiling, the paddle and bricks, detects loss at the floor, and tracks remaining lives.
- Feeds the renderer (x, y, raio) and the game controller (perdeu, fim_jogo).

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- RAIO, 5, ball radius in pixels
- DIV, 50000, CLOCK_50 cycles per movement step (tick period)
- VIDAS, 3, lives at start or restart (1..7)
- VEL_MAX, 4, maximum pixels per step per axis
- ACELERA, 8, paddle hits needed per +1 speed

Ports:
- CLOCK_50  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-low: 0 = reset
- pausa  input  1  level; while 1, the ball position is frozen
- reiniciar  input  1  synchronous one-cycle pulse that restarts the game
- lancar  input  1  synchronous pulse; launches the ball from ESPERA
- raquete_x  input  10  left edge of the paddle
- raquete_y  input  10  top edge of the paddle
- raquete_larg  input  10  paddle width
- colisao_bloco  input  1  one-cycle pulse from the brick module
- x  output  10  ball centre, x
- y  output  10  ball centre, y
- raio  output  10  constant RAIO
- vidas  output  3  lives remaining
- perdeu  output  1  one-cycle pulse when the ball is lost
- fim_jogo  output  1  level; 1 in state FIM

Behaviour:

Reset (reset=0, asynchronous):
- estado=ESPERA; vidas=VIDAS; vel=1; dx=+; dy=-.
- x=SCREEN_W/2; y=SCREEN_H-40.
- perdeu=0; fim_jogo=0; tick counter=0; bloco_pend=0.

Tick generator:
- Counter runs 0..DIV-1 and always counts, even during pausa.
- tick is a one-cycle enable when the counter is at DIV-1.
- No derived clocks; all logic runs on CLOCK_50.

bloco_pend:
- Set by colisao_bloco.
- Cleared on the next tick that is processed in MOVENDO.
- Cleared by reiniciar.

Priority, highest first: reset > reiniciar > pausa > lancar/tick.
- reiniciar: estado=ESPERA, vidas=VIDAS, vel=1, dx=+, dy=-, paddle-hit counter=0, fim_jogo=0.

ESPERA:
- Every cycle, x = raquete_x + raquete_larg/2 and y = raquete_y - RAIO - 1. The ball follows the paddle, and this tracking continues during pausa.
- lancar with pausa=0: go to MOVENDO with dx=+, dy=-.

MOVENDO, on each tick with pausa=0:
- Step: nx = x ± vel, ny = y ± vel. Use 12-bit signed intermediates; no wrap is allowed.
- Left wall: if nx-RAIO ≤ 0, then x=RAIO and dx=+.
- Right wall: if nx+RAIO ≥ SCREEN_W-1, then x=SCREEN_W-1-RAIO and dx=-.
- Ceiling: if ny-RAIO ≤ 0, then y=RAIO and dy=+.
- Paddle hit requires all of:
  - dy=+
  - y+RAIO < raquete_y ≤ ny+RAIO
  - raquete_x ≤ nx ≤ raquete_x+raquete_larg
- On a paddle hit:
  - y = raquete_y-RAIO-1 and dy=-.
  - Increment the hit counter. When it reaches ACELERA, clear it and set vel = min(vel+1, VEL_MAX).
- Brick: if bloco_pend and there is no paddle hit on this tick, dy is inverted after the wall/ceiling checks. A ceiling hit and a brick on the same tick give net dy=- (the ceiling flips dy to +, then the brick inverts it).
- Corner: both axis checks apply independently, so both dx and dy can flip on the same tick.
- Floor: if ny+RAIO ≥ SCREEN_H-1 and there is no paddle hit:
  - perdeu=1 for one cycle; vidas decrements.
  - If the new vidas > 0, go to ESPERA; otherwise go to FIM.

FIM:
- fim_jogo=1; the ball is frozen.
- Leave only on reiniciar or reset.

Output latency:
- x and y update on the cycle after the tick; they are registered outputs.
- raio is a constant.

Decomposition:
- Shared package (bola_pkg):
  - Estado enum: ESPERA, MOVENDO, FIM.
  - Default SCREEN_W and SCREEN_H.
  - Direction encoding: 1=positive.
  - Coordinate width (10) and intermediate width (12).
- Sub-module divisor_tick (parameter DIV; ports CLOCK_50, reset, tick): a single counter, reusable by the paddle and brick modules.

Test Plan (DIV=4):
- Reset, then raquete_x=300, raquete_larg=40, raquete_y=450 → within 1 cycle, x=320, y=444; vidas=3; fim_jogo=0.
- Launch from x=320, y=444 with vel=1 → after 1 tick, x=321, y=443. Hold pausa=1 for 20 cycles → x and y unchanged; then resume.
- Force x=636, dx=+, y=100 (via placement) → next tick: x=634, dx=-. Same test at the ceiling: y=RAIO, dy flips to +. Corner (x=634, y=5) flips both.
- Paddle hit ×8 with ACELERA=8 → vel becomes 2 and the step size doubles. Paddle hit and colisao_bloco on the same tick → dy=- (paddle wins).
- Miss the paddle (raquete_x=0, ball at x=500 descending) → perdeu pulses once; vidas 3→2; estado=ESPERA. Repeat → vidas=0, fim_jogo=1; lancar is ignored.
- reiniciar in FIM → vidas=3, vel=1, fim_jogo=0. reset=0 asserted mid-MOVENDO → all outputs take reset values immediately, asynchronously.
